// File: rtl/apb_slave_mem.sv
// APB responder with NUM_SLV word-addressed register banks, programmable wait states,
// error responses and saturating completed-transfer counters.
module apb_slave_mem #(
    parameter int NUM_SLV     = 4,
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic               Hclk,
    input  logic               Hreset,
    input  logic [NUM_SLV-1:0] Pselx,
    input  logic               Penable,
    input  logic               Pwrite,
    input  logic [31:0]        Paddr,
    input  logic [31:0]        Pwdata,
    output logic [31:0]        Prdata,
    output logic               Pready,
    output logic               Pslverr,
    output logic [15:0]        wr_cnt,
    output logic [15:0]        rd_cnt
);

    localparam int IW = $clog2(DEPTH);
    localparam int SW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int AW = SW + IW;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t             state_q;
    logic               wr_q;
    logic               err_q;
    logic [AW-1:0]      addr_q;
    logic [31:0]        wdata_q;
    logic [31:0]        rdata_q;
    logic [3:0]         wcnt_q;
    logic [15:0]        wr_cnt_q, wr_cnt_d;
    logic [15:0]        rd_cnt_q, rd_cnt_d;
    logic [31:0]        mem_q [NUM_SLV*DEPTH];
    logic               req_err;

    function automatic logic [SW-1:0] sel_index(input logic [NUM_SLV-1:0] s);
        logic [SW-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (s[i]) idx = SW'(i);
        end
        return idx;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    always_comb begin
        req_err  = !$onehot(Pselx) || (Paddr[1:0] != 2'b00) || ((Paddr >> (IW + 2)) != 32'd0);
        Pready   = (state_q == ACCESS) && (wcnt_q == 4'd0);
        Pslverr  = Pready && err_q;
        Prdata   = (Pready && !wr_q && !err_q) ? rdata_q : 32'h0;
        wr_cnt_d = sat_inc(wr_cnt_q);
        rd_cnt_d = sat_inc(rd_cnt_q);
    end

    assign wr_cnt = wr_cnt_q;
    assign rd_cnt = rd_cnt_q;

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state_q  <= IDLE;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            wcnt_q   <= '0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            for (int i = 0; i < NUM_SLV*DEPTH; i++) mem_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|Pselx) begin
                        // Penable already high here means the master skipped the setup phase
                        wr_q    <= Pwrite;
                        err_q   <= Penable || req_err;
                        addr_q  <= {sel_index(Pselx), Paddr[IW+1:2]};
                        wdata_q <= Pwdata;
                        wcnt_q  <= 4'(WAIT_STATES);
                        state_q <= Penable ? ACCESS : SETUP;
                    end
                end
                SETUP: begin
                    if (!wr_q && !err_q) rdata_q <= mem_q[addr_q];
                    state_q <= ACCESS;
                end
                ACCESS: begin
                    if (Pselx == '0) begin
                        state_q <= IDLE;
                    end else begin
                        if (wcnt_q != 4'd0) wcnt_q <= wcnt_q - 4'd1;
                        if (Penable && Pready) begin
                            if (!err_q) begin
                                if (wr_q) begin
                                    mem_q[addr_q] <= wdata_q;
                                    wr_cnt_q      <= wr_cnt_d;
                                end else begin
                                    rd_cnt_q <= rd_cnt_d;
                                end
                            end
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench: a WAIT_STATES=0 instance driven from a vector table plus hand sequences,
// and a WAIT_STATES=3 instance for wait-state and dropped-transfer behaviour.
module tb_apb_slave_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  sel0, sel3;
    logic        pen, pwr;
    logic [31:0] addr, wdata;
    logic [31:0] rd0, rd3;
    logic        rdy0, rdy3, err0, err3;
    logic [15:0] wc0, rc0, wc3, rc3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    apb_slave_mem #(.NUM_SLV(4), .DEPTH(16), .WAIT_STATES(0)) u0 (
        .Hclk(clk), .Hreset(rst), .Pselx(sel0), .Penable(pen), .Pwrite(pwr),
        .Paddr(addr), .Pwdata(wdata), .Prdata(rd0), .Pready(rdy0), .Pslverr(err0),
        .wr_cnt(wc0), .rd_cnt(rc0));

    apb_slave_mem #(.NUM_SLV(4), .DEPTH(16), .WAIT_STATES(3)) u3 (
        .Hclk(clk), .Hreset(rst), .Pselx(sel3), .Penable(pen), .Pwrite(pwr),
        .Paddr(addr), .Pwdata(wdata), .Prdata(rd3), .Pready(rdy3), .Pslverr(err3),
        .wr_cnt(wc3), .rd_cnt(rc3));

    typedef struct {
        logic        w;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [15:0] exp_wc;
        logic [15:0] exp_rc;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One APB transfer; address/data are scrambled after setup to prove latched values are used.
    task automatic xfer(input bit d3, input logic w, input logic [3:0] s, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rdata, output logic err,
                        output int cyc);
        bit got;
        got = 1'b0; rdata = '0; err = 1'b0; cyc = 0;
        @(negedge clk);
        sel0 = d3 ? 4'h0 : s; sel3 = d3 ? s : 4'h0;
        pen = 1'b0; pwr = w; addr = a; wdata = d;
        @(negedge clk);
        pen = 1'b1; addr = ~a; wdata = ~d;
        for (int k = 0; k < 40; k++) begin
            #1;
            cyc++;
            if (d3 ? rdy3 : rdy0) begin
                rdata = d3 ? rd3 : rd0;
                err   = d3 ? err3 : err0;
                got   = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("xfer_ready_seen", 32'(got), 32'd1);
        @(negedge clk);
        sel0 = 4'h0; sel3 = 4'h0; pen = 1'b0;
        #1;
        chk("pready_drops_after_completion", 32'(d3 ? rdy3 : rdy0), 32'd0);
    endtask

    initial begin
        logic [31:0] r;
        logic        e;
        int          c;

        tbl[0]  = '{1'b1, 4'h1, 32'h08, 32'hDEADBEEF, 32'h0,        1'b0, 16'd1, 16'd0};
        tbl[1]  = '{1'b0, 4'h1, 32'h08, 32'h0,        32'hDEADBEEF, 1'b0, 16'd1, 16'd1};
        tbl[2]  = '{1'b1, 4'h2, 32'h04, 32'h11,       32'h0,        1'b0, 16'd2, 16'd1};
        tbl[3]  = '{1'b0, 4'h4, 32'h04, 32'h0,        32'h0,        1'b0, 16'd2, 16'd2};
        tbl[4]  = '{1'b0, 4'h2, 32'h04, 32'h0,        32'h11,       1'b0, 16'd2, 16'd3};
        tbl[5]  = '{1'b1, 4'h1, 32'h42, 32'h99,       32'h0,        1'b1, 16'd2, 16'd3};
        tbl[6]  = '{1'b1, 4'h1, 32'h40, 32'h5,        32'h0,        1'b1, 16'd2, 16'd3};
        tbl[7]  = '{1'b1, 4'h3, 32'h08, 32'h77,       32'h0,        1'b1, 16'd2, 16'd3};
        tbl[8]  = '{1'b0, 4'h1, 32'h40, 32'h0,        32'h0,        1'b1, 16'd2, 16'd3};
        tbl[9]  = '{1'b0, 4'h1, 32'h08, 32'h0,        32'hDEADBEEF, 1'b0, 16'd2, 16'd4};
        tbl[10] = '{1'b0, 4'h1, 32'h00, 32'h0,        32'h0,        1'b0, 16'd2, 16'd5};
        tbl[11] = '{1'b1, 4'h8, 32'h3C, 32'hA5A5A5A5, 32'h0,        1'b0, 16'd3, 16'd5};
        tbl[12] = '{1'b0, 4'h8, 32'h3C, 32'h0,        32'hA5A5A5A5, 1'b0, 16'd3, 16'd6};
        tbl[13] = '{1'b0, 4'h1, 32'h0A, 32'h0,        32'h0,        1'b1, 16'd3, 16'd6};

        rst = 1'b1; sel0 = '0; sel3 = '0; pen = 1'b0; pwr = 1'b0; addr = '0; wdata = '0;
        repeat (2) @(negedge clk);
        chk("reset_prdata", rd0, 32'h0);
        chk("reset_pready", 32'(rdy0), 32'd0);
        chk("reset_pslverr", 32'(err0), 32'd0);
        chk("reset_wr_cnt", 32'(wc0), 32'd0);
        chk("reset_rd_cnt", 32'(rc0), 32'd0);
        rst = 1'b0;

        // Table-driven transfers on the zero-wait-state instance
        for (int i = 0; i < 14; i++) begin
            xfer(1'b0, tbl[i].w, tbl[i].sel, tbl[i].addr, tbl[i].wdata, r, e, c);
            chk($sformatf("vec%0d_prdata", i), r, tbl[i].exp_rdata);
            chk($sformatf("vec%0d_pslverr", i), 32'(e), 32'(tbl[i].exp_err));
            chk($sformatf("vec%0d_penable_cycles", i), 32'(c), 32'd2);
            chk($sformatf("vec%0d_wr_cnt", i), 32'(wc0), 32'(tbl[i].exp_wc));
            chk($sformatf("vec%0d_rd_cnt", i), 32'(rc0), 32'(tbl[i].exp_rc));
        end

        // Penable raised without a setup phase: error, no write
        @(negedge clk);
        sel0 = 4'h1; pen = 1'b1; pwr = 1'b1; addr = 32'h08; wdata = 32'h1234;
        @(negedge clk); #1;
        chk("nosetup_pready", 32'(rdy0), 32'd1);
        chk("nosetup_pslverr", 32'(err0), 32'd1);
        @(negedge clk);
        sel0 = 4'h0; pen = 1'b0;
        xfer(1'b0, 1'b0, 4'h1, 32'h08, 32'h0, r, e, c);
        chk("nosetup_mem_kept", r, 32'hDEADBEEF);
        chk("nosetup_wr_cnt", 32'(wc0), 32'd3);
        chk("nosetup_rd_cnt", 32'(rc0), 32'd7);

        // Three wait states: Pready in the 4th ACCESS cycle, one setup-state cycle before it
        xfer(1'b1, 1'b0, 4'h1, 32'h00, 32'h0, r, e, c);
        chk("w3_read_cycles", 32'(c), 32'd5);
        chk("w3_read_prdata", r, 32'h0);
        chk("w3_rd_cnt", 32'(rc3), 32'd1);

        // Pselx dropped while waiting: transfer abandoned
        @(negedge clk);
        sel3 = 4'h1; pen = 1'b0; pwr = 1'b0; addr = 32'h0;
        @(negedge clk);
        pen = 1'b1; #1;
        chk("drop_pready_setup", 32'(rdy3), 32'd0);
        @(negedge clk); #1;
        chk("drop_pready_access1", 32'(rdy3), 32'd0);
        @(negedge clk);
        sel3 = 4'h0; #1;
        chk("drop_pready_access2", 32'(rdy3), 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); #1;
            chk($sformatf("drop_idle_pready%0d", k), 32'(rdy3), 32'd0);
        end
        pen = 1'b0;
        chk("drop_rd_cnt", 32'(rc3), 32'd1);
        xfer(1'b1, 1'b1, 4'h2, 32'h04, 32'hCAFE, r, e, c);
        chk("w3_write_cycles", 32'(c), 32'd5);
        chk("w3_wr_cnt", 32'(wc3), 32'd1);
        xfer(1'b1, 1'b0, 4'h2, 32'h04, 32'h0, r, e, c);
        chk("w3_readback", r, 32'hCAFE);
        chk("w3_rd_cnt2", 32'(rc3), 32'd2);

        // Reset during the ACCESS cycle of a write
        @(negedge clk);
        sel0 = 4'h1; pen = 1'b0; pwr = 1'b1; addr = 32'h0; wdata = 32'h55;
        @(negedge clk);
        pen = 1'b1;
        @(negedge clk); #1;
        chk("rstmid_pready_before", 32'(rdy0), 32'd1);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("rstmid_prdata", rd0, 32'h0);
        chk("rstmid_pready", 32'(rdy0), 32'd0);
        chk("rstmid_pslverr", 32'(err0), 32'd0);
        chk("rstmid_wr_cnt", 32'(wc0), 32'd0);
        chk("rstmid_rd_cnt", 32'(rc0), 32'd0);
        chk("rstmid_w3_rd_cnt", 32'(rc3), 32'd0);
        rst = 1'b0; sel0 = 4'h0; pen = 1'b0;
        xfer(1'b0, 1'b0, 4'h1, 32'h00, 32'h0, r, e, c);
        chk("rstmid_no_write", r, 32'h0);
        xfer(1'b0, 1'b0, 4'h1, 32'h08, 32'h0, r, e, c);
        chk("rstmid_mem_cleared", r, 32'h0);
        chk("rstmid_rd_cnt_after", 32'(rc0), 32'd2);

        // Write counter saturation
        @(negedge clk);
        force u0.wr_cnt_q = 16'hFFFE;
        @(negedge clk);
        release u0.wr_cnt_q;
        #1;
        chk("sat_preload", 32'(wc0), 32'hFFFE);
        xfer(1'b0, 1'b1, 4'h1, 32'h10, 32'h1, r, e, c);
        chk("sat_first", 32'(wc0), 32'hFFFF);
        xfer(1'b0, 1'b1, 4'h1, 32'h14, 32'h2, r, e, c);
        chk("sat_hold", 32'(wc0), 32'hFFFF);
        chk("sat_rd_cnt", 32'(rc0), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
